// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    typedef enum logic {
        GntIf = 1'b0,
        GntDm = 1'b1
    } grant_e;

    localparam int unsigned DefDataW = 32;
    localparam logic [DefDataW-1:0] RDataRst = '0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and backing-memory signals of the arbiter, plus pipeline stall and error.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_ack_o;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              stall_o;
    logic              err_o;

    // Arbiter side
    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
               mem_ack_i, mem_rdata_i,
        output if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
    );

    // Requesters and backing memory side
    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
               mem_ack_i, mem_rdata_i,
        input  if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter; expire_o flags the TIMEOUT-th enabled cycle (never when TIMEOUT is 0).
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != LastCnt)) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    // r_cnt holds completed cycles, so the current cycle is number r_cnt + 1
    assign expire_o = (TIMEOUT != 0) && en_i && (r_cnt == LastCnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports: data-first with a fairness
// limit, one outstanding access, and a watchdog that aborts hung transactions.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FAIR_LIMIT = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] FairLim = 4'(FAIR_LIMIT);

    state_e            r_state;
    grant_e            r_gnt;
    logic [3:0]        r_fair_cnt;
    logic              r_err;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic              w_gnt_dm;
    logic              w_busy;
    logic              w_expire;
    logic [DATA_W-1:0] w_rd_val;

    // Fetch wins a contested grant only once data has used up its consecutive quota
    assign w_gnt_dm = bus.dm_req_i & (~bus.if_req_i | (r_fair_cnt != FairLim));
    assign w_busy   = (r_state == StBusy);
    assign w_rd_val = bus.mem_ack_i ? bus.mem_rdata_i : DATA_W'(RDataRst);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (~w_busy),
        .en_i     (w_busy),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_gnt       <= GntIf;
            r_fair_cnt  <= '0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= DATA_W'(RDataRst);
            r_dm_rdata  <= DATA_W'(RDataRst);
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.if_req_i || bus.dm_req_i) begin
                        r_state   <= StBusy;
                        r_mem_req <= 1'b1;
                        if (w_gnt_dm) begin
                            r_gnt       <= GntDm;
                            r_mem_we    <= bus.dm_we_i;
                            r_mem_addr  <= bus.dm_addr_i;
                            r_mem_wdata <= bus.dm_wdata_i;
                            if (bus.if_req_i && (r_fair_cnt != FairLim)) begin
                                r_fair_cnt <= r_fair_cnt + 4'd1;
                            end
                        end else begin
                            r_gnt       <= GntIf;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= bus.if_addr_i;
                            r_mem_wdata <= '0;
                            r_fair_cnt  <= '0;
                        end
                    end
                end
                StBusy: begin
                    // A real ack in the expiry cycle takes priority over the abort
                    if (bus.mem_ack_i || w_expire) begin
                        r_state   <= StResp;
                        r_mem_req <= 1'b0;
                        if (!bus.mem_ack_i) begin
                            r_err <= 1'b1;
                        end
                        if (r_gnt == GntDm) begin
                            r_dm_ack <= 1'b1;
                            if (!r_mem_we) begin
                                r_dm_rdata <= w_rd_val;
                            end
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_rd_val;
                        end
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_mem_wdata;
    assign bus.if_ack_o    = r_if_ack;
    assign bus.dm_ack_o    = r_dm_ack;
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.dm_rdata_o  = r_dm_rdata;
    assign bus.err_o       = r_err;
    assign bus.stall_o     = (bus.if_req_i & ~r_if_ack) | (bus.dm_req_i & ~r_dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expected grants/acks are queued with the stimulus, a monitor pops them.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned FAIR = 4;
    localparam int unsigned TMO  = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
    } rsp_t;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FAIR_LIMIT (FAIR),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    mreq_t       exp_mem[$];
    rsp_t        exp_rsp[$];
    int          total = 0;
    int          bad = 0;
    int          mem_lat = 1;
    bit          mem_hang = 0;
    int          mcnt;
    int          req_len;
    int          last_req_len;
    logic        prev_req;
    logic [31:0] mem_arr [logic [31:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "time limit reached");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_grant(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        mreq_t m;
        m.addr  = addr;
        m.we    = we;
        m.wdata = wdata;
        exp_mem.push_back(m);
    endtask

    task automatic exp_ack(input logic port, input logic [31:0] rdata);
        rsp_t r;
        r.port  = port;
        r.rdata = rdata;
        exp_rsp.push_back(r);
    endtask

    task automatic dm_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        bit got = 0;
        bus.dm_req_i   = 1'b1;
        bus.dm_addr_i  = addr;
        bus.dm_we_i    = we;
        bus.dm_wdata_i = wdata;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.dm_ack_o) begin
                got = 1;
                break;
            end
        end
        bus.dm_req_i = 1'b0;
        bus.dm_we_i  = 1'b0;
        check("dm_ack_seen", 64'(got), 64'd1);
    endtask

    task automatic if_access(input logic [31:0] addr);
        bit got = 0;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = addr;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.if_ack_o) begin
                got = 1;
                break;
            end
        end
        bus.if_req_i = 1'b0;
        check("if_ack_seen", 64'(got), 64'd1);
    endtask

    // Backing memory: acks mem_lat cycles after first seeing mem_req_o, unless hung
    initial begin
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        mcnt = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_ack_i) begin
                bus.mem_ack_i   = 1'b0;
                bus.mem_rdata_i = '0;
                mcnt = 0;
            end else if (bus.mem_req_o) begin
                mcnt++;
                if (!mem_hang && mcnt == mem_lat + 1) begin
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_we_o) begin
                        mem_arr[bus.mem_addr_o] = bus.mem_wdata_o;
                    end else begin
                        bus.mem_rdata_i = mem_arr.exists(bus.mem_addr_o) ?
                                          mem_arr[bus.mem_addr_o] : 32'h0;
                    end
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Monitor
    initial begin
        mreq_t m;
        rsp_t  r;
        prev_req = 1'b0;
        req_len = 0;
        last_req_len = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_req_o && !prev_req) begin
                if (exp_mem.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got addr 0x%0h, no grant expected",
                             bus.mem_addr_o);
                end else begin
                    m = exp_mem.pop_front();
                    check("grant_addr", 64'(bus.mem_addr_o), 64'(m.addr));
                    check("grant_we", 64'(bus.mem_we_o), 64'(m.we));
                    if (m.we) check("grant_wdata", 64'(bus.mem_wdata_o), 64'(m.wdata));
                end
                req_len = 0;
            end
            if (bus.mem_req_o) req_len++;
            else if (prev_req) last_req_len = req_len;
            prev_req = bus.mem_req_o;
            if (bus.if_ack_o || bus.dm_ack_o) begin
                if (exp_rsp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b, none expected",
                             bus.if_ack_o, bus.dm_ack_o);
                end else begin
                    r = exp_rsp.pop_front();
                    check("ack_port", 64'({bus.if_ack_o, bus.dm_ack_o}),
                          r.port ? 64'd1 : 64'd2);
                    check("ack_rdata", r.port ? 64'(bus.dm_rdata_o) : 64'(bus.if_rdata_o),
                          64'(r.rdata));
                end
            end
        end
    end

    initial begin
        bit seen;
        rst = 1'b1;
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = '0;
        bus.dm_req_i   = 1'b0;
        bus.dm_we_i    = 1'b0;
        bus.dm_addr_i  = '0;
        bus.dm_wdata_i = '0;
        mem_arr[32'h10]  = 32'h0050_0093;
        mem_arr[32'h40]  = 32'h00A0_0113;
        mem_arr[32'h44]  = 32'h00B0_0193;
        mem_arr[32'h100] = 32'h1111_0000;
        mem_arr[32'h104] = 32'h2222_0000;
        mem_arr[32'h108] = 32'h3333_0000;
        mem_arr[32'h10C] = 32'h4444_0000;
        mem_arr[32'h110] = 32'h5555_0000;
        mem_arr[32'h114] = 32'h6666_0000;
        repeat (2) @(negedge clk);

        check("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we_o), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata_o), 64'd0);
        check("rst_acks", 64'({bus.if_ack_o, bus.dm_ack_o}), 64'd0);
        check("rst_if_rdata", 64'(bus.if_rdata_o), 64'd0);
        check("rst_dm_rdata", 64'(bus.dm_rdata_o), 64'd0);
        check("rst_err", 64'(bus.err_o), 64'd0);
        check("rst_stall", 64'(bus.stall_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch
        exp_grant(32'h10, 1'b0, 32'h0);
        exp_ack(1'b0, 32'h0050_0093);
        if_access(32'h10);
        @(negedge clk);
        check("fetch_stall_after_ack", 64'(bus.stall_o), 64'd0);
        check("fetch_req_len", 64'(last_req_len), 64'd2);

        // Write then read back; the write must not touch dm_rdata_o
        exp_grant(32'h20, 1'b1, 32'hDEAD_BEEF);
        exp_ack(1'b1, 32'h0);
        dm_access(32'h20, 1'b1, 32'hDEAD_BEEF);
        exp_grant(32'h20, 1'b0, 32'h0);
        exp_ack(1'b1, 32'hDEAD_BEEF);
        dm_access(32'h20, 1'b0, 32'h0);
        check("if_rdata_hold", 64'(bus.if_rdata_o), 64'h0050_0093);

        // Contention: DM x4, IF, DM x2, IF
        for (int k = 0; k < 4; k++) exp_grant(32'h100 + 32'(4 * k), 1'b0, 32'h0);
        exp_grant(32'h40, 1'b0, 32'h0);
        exp_grant(32'h110, 1'b0, 32'h0);
        exp_grant(32'h114, 1'b0, 32'h0);
        exp_grant(32'h44, 1'b0, 32'h0);
        exp_ack(1'b1, 32'h1111_0000);
        exp_ack(1'b1, 32'h2222_0000);
        exp_ack(1'b1, 32'h3333_0000);
        exp_ack(1'b1, 32'h4444_0000);
        exp_ack(1'b0, 32'h00A0_0113);
        exp_ack(1'b1, 32'h5555_0000);
        exp_ack(1'b1, 32'h6666_0000);
        exp_ack(1'b0, 32'h00B0_0193);
        fork
            begin
                for (int k = 0; k < 6; k++) dm_access(32'h100 + 32'(4 * k), 1'b0, 32'h0);
            end
            begin
                for (int k = 0; k < 2; k++) if_access(32'h40 + 32'(4 * k));
            end
        join

        // Hung memory: abort after TMO busy cycles, fetch returns 0, err sticks
        mem_hang = 1'b1;
        exp_grant(32'h50, 1'b0, 32'h0);
        exp_ack(1'b0, 32'h0);
        if_access(32'h50);
        @(negedge clk);
        check("timeout_req_len", 64'(last_req_len), 64'(TMO));
        check("timeout_err", 64'(bus.err_o), 64'd1);
        mem_hang = 1'b0;
        exp_grant(32'h10C, 1'b0, 32'h0);
        exp_ack(1'b1, 32'h4444_0000);
        dm_access(32'h10C, 1'b0, 32'h0);
        check("err_sticky", 64'(bus.err_o), 64'd1);

        rst = 1'b1;
        @(negedge clk);
        check("err_cleared_by_rst", 64'(bus.err_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ack in the expiry cycle completes normally
        mem_lat = 7;
        exp_grant(32'h104, 1'b0, 32'h0);
        exp_ack(1'b1, 32'h2222_0000);
        dm_access(32'h104, 1'b0, 32'h0);
        @(negedge clk);
        check("coincide_req_len", 64'(last_req_len), 64'(TMO));
        check("coincide_err", 64'(bus.err_o), 64'd0);
        mem_lat = 1;

        // Reset while BUSY, request held across reset
        mem_hang = 1'b1;
        exp_grant(32'h108, 1'b0, 32'h0);
        bus.dm_req_i  = 1'b1;
        bus.dm_addr_i = 32'h108;
        bus.dm_we_i   = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req_o) begin
                seen = 1;
                break;
            end
        end
        check("busy_before_rst", 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_drops_req_now", 64'(bus.mem_req_o), 64'd0);
        mem_hang = 1'b0;
        @(negedge clk);
        check("rst_mid_err", 64'(bus.err_o), 64'd0);
        check("rst_mid_no_ack", 64'(bus.dm_ack_o), 64'd0);
        exp_grant(32'h108, 1'b0, 32'h0);
        exp_ack(1'b1, 32'h3333_0000);
        rst = 1'b0;
        @(negedge clk);
        check("regrant_next_cycle", 64'(bus.mem_req_o), 64'd1);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.dm_ack_o) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        bus.dm_req_i = 1'b0;
        check("regrant_ack_seen", 64'(seen), 64'd1);

        repeat (3) @(negedge clk);
        check("grants_all_seen", 64'(exp_mem.size()), 64'd0);
        check("acks_all_seen", 64'(exp_rsp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the instruction-fetch port and the data-memory port of the 5-stage pipelined CPU.
- Sequences each access with a req/ack handshake and returns read data to the winning port.
- Raises stall_o so that PC, IF/ID and later stages freeze while an access is pending.
- Grants the data port first, with a fairness limit so fetch is never starved, and a watchdog that aborts hung memory transactions.

Parameters:
- ADDR_W, 32, address width for both ports and the memory.
- DATA_W, 32, data width.
- FAIR_LIMIT, 4, max consecutive data-port grants while fetch is waiting; range 1..15.
- TIMEOUT, 255, max cycles in BUSY before abort; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- if_rdata_o  out  DATA_W  fetched instruction.
- dm_req_i  in  1  data request; held until dm_ack_o.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  write data.
- dm_ack_o  out  1  one-cycle data completion pulse.
- dm_rdata_o  out  DATA_W  load data.
- mem_req_o  out  1  backing memory request.
- mem_we_o  out  1  backing memory write enable.
- mem_addr_o  out  ADDR_W  backing memory address.
- mem_wdata_o  out  DATA_W  backing memory write data.
- mem_ack_i  in  1  backing memory done; valid for one cycle.
- mem_rdata_i  in  DATA_W  backing read data, valid with mem_ack_i.
- stall_o  out  1  pipeline freeze.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, immediate): state IDLE. All of the following are 0:
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  - if_ack_o, dm_ack_o, if_rdata_o, dm_rdata_o
  - err_o, fairness counter, watchdog counter
- Reset mid-transaction: mem_req_o drops at once, and no ack is issued for the aborted access.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No requests: stay in IDLE.
  - Any request: choose the grant, register addr/we/wdata onto the mem_* outputs, set mem_req_o=1, go to BUSY. mem_req_o rises the cycle after the request is first sampled.
  - Fetch grants always have mem_we_o=0.
- Grant rule:
  - dm_req_i only: grant data.
  - if_req_i only: grant fetch.
  - Both: grant data unless fair_cnt==FAIR_LIMIT, in which case grant fetch.
- Fairness counter:
  - Increments on a data grant while if_req_i=1; saturates at FAIR_LIMIT.
  - Clears on any fetch grant.
  - Unchanged on a data grant with if_req_i=0.
- BUSY:
  - mem_* outputs stay stable.
  - On mem_ack_i: drop mem_req_o, go to RESP. For a read, capture mem_rdata_i into the granted port's rdata register.
  - Writes leave dm_rdata_o unchanged.
- RESP: pulse the granted port's ack_o for exactly one cycle, then return to IDLE. Requests are not sampled in RESP, because the requester drops req on ack.
- Minimum access = 3 cycles (grant, ack, resp) with 1-cycle memory latency.
- rdata outputs hold their value until the next read completion on the same port.
- Watchdog:
  - Counts cycles in BUSY; clears on leaving BUSY.
  - When the count reaches TIMEOUT (with TIMEOUT≠0) and mem_ack_i=0: drop mem_req_o, set err_o=1 (sticky until reset), go to RESP.
  - The RESP ack still pulses; for a read, the port's rdata is loaded with 0.
- mem_ack_i arriving in the same cycle as timeout: the ack wins, no error.
- mem_ack_i outside BUSY is ignored.
- stall_o is combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
- No new grant is issued until the current transaction reaches RESP; there is at most one outstanding access.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum (IDLE/BUSY/RESP)
  - grant encoding (GNT_IF=0, GNT_DM=1)
  - a reset-value constant for the data width.
- One natural sub-module, mem_arb_watchdog: a TIMEOUT-parameterised down/up counter with clear and enable inputs and an expire output.
- The arbiter FSM and fairness counter live in the top module.

Test Plan:
- Single fetch, addr 0x10, mem_ack 1 cycle later with rdata 0x00500093 -> mem_req_o high for 2 cycles, mem_we_o=0, if_ack_o pulses once with if_rdata_o=0x00500093, stall_o low the cycle after ack.
- Data write, addr 0x20, wdata 0xDEADBEEF -> mem_we_o=1, mem_wdata_o=0xDEADBEEF, dm_ack_o single pulse, dm_rdata_o unchanged from 0.
- Fetch and data requested continuously with FAIR_LIMIT=4 -> grant sequence DM, DM, DM, DM, IF, DM..., fair_cnt clears after the IF grant.
- Memory never acks with TIMEOUT=8 -> mem_req_o drops after 8 BUSY cycles, err_o=1 and stays set, the port acks with rdata 0, the next request proceeds normally.
- mem_ack_i in the same cycle as watchdog expiry -> normal completion, err_o stays 0.
- rst_i asserted mid-BUSY -> mem_req_o=0 immediately, no ack pulse, state IDLE, err_o=0; the request still held after reset is re-granted the cycle after release.
